// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, control enums, control bundle and decode helpers.
package decode_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned IDX_W  = 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_sel_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    WB_ALU    = 2'd0,
    WB_MEM    = 2'd1,
    WB_PC_INC = 2'd2
  } wb_sel_e;

  typedef struct packed {
    logic [2:0] load_store_mode;
    logic       reg_wr_en;
    logic       alu_src_1_sel;
    logic       alu_src_2_sel;
    logic       br_u;
    logic       mem_rw;
    logic       pc_sel;
    imm_sel_e   imm_sel;
    alu_sel_e   alu_sel;
    wb_sel_e    wb_sel;
    logic       illegal;
  } ctrl_t;

  // Formats that read rs1.
  function automatic logic uses_rs1(input logic [INST_W-1:0] inst);
    return (inst[6:0] == OP_REG)    || (inst[6:0] == OP_IMM)   ||
           (inst[6:0] == OP_LOAD)   || (inst[6:0] == OP_STORE) ||
           (inst[6:0] == OP_BRANCH) || (inst[6:0] == OP_JALR);
  endfunction

  // Formats that read rs2.
  function automatic logic uses_rs2(input logic [INST_W-1:0] inst);
    return (inst[6:0] == OP_REG) || (inst[6:0] == OP_STORE) ||
           (inst[6:0] == OP_BRANCH);
  endfunction

  // Formats that carry a destination register.
  function automatic logic uses_rd(input logic [INST_W-1:0] inst);
    return (inst[6:0] == OP_REG)  || (inst[6:0] == OP_IMM)  ||
           (inst[6:0] == OP_LOAD) || (inst[6:0] == OP_JAL)  ||
           (inst[6:0] == OP_JALR) || (inst[6:0] == OP_LUI)  ||
           (inst[6:0] == OP_AUIPC);
  endfunction

  // Register index beyond the implemented register file.
  function automatic logic idx_oob(input logic [IDX_W-1:0] idx, input int unsigned num_regs);
    return {1'b0, idx} >= 6'(num_regs);
  endfunction

  // ALU op from funct3; alt is inst[30], honoured for SUB only on register ops.
  function automatic alu_sel_e alu_op(input logic [2:0] f3, input logic alt, input logic is_reg);
    alu_sel_e op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // 32-bit immediate assembly for the selected format, sign-extended.
  function automatic logic [31:0] gen_imm(input logic [INST_W-1:0] i, input imm_sel_e sel);
    logic [31:0] imm;
    imm = {{20{i[31]}}, i[31:20]};
    case (sel)
      IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   imm = {i[31:12], 12'd0};
      IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = {{20{i[31]}}, i[31:20]};
    endcase
    return imm;
  endfunction

  // Full control decode including illegal detection and its suppression of side effects.
  function automatic ctrl_t decode_ctrl(input logic [INST_W-1:0] inst, input int unsigned num_regs);
    ctrl_t c;
    logic  bad_idx;
    c = '0;
    case (inst[6:0])
      OP_LUI: begin
        c.reg_wr_en = 1'b1; c.alu_src_2_sel = 1'b1; c.imm_sel = IMM_U; c.alu_sel = ALU_PASS_B;
      end
      OP_AUIPC: begin
        c.reg_wr_en = 1'b1; c.alu_src_1_sel = 1'b1; c.alu_src_2_sel = 1'b1; c.imm_sel = IMM_U;
      end
      OP_JAL: begin
        c.reg_wr_en = 1'b1; c.alu_src_1_sel = 1'b1; c.alu_src_2_sel = 1'b1; c.pc_sel = 1'b1;
        c.imm_sel = IMM_J; c.wb_sel = WB_PC_INC;
      end
      OP_JALR: begin
        c.reg_wr_en = 1'b1; c.alu_src_2_sel = 1'b1; c.pc_sel = 1'b1; c.wb_sel = WB_PC_INC;
      end
      OP_BRANCH: begin
        c.pc_sel = 1'b1; c.br_u = inst[13]; c.imm_sel = IMM_B;
      end
      OP_LOAD: begin
        c.reg_wr_en = 1'b1; c.alu_src_2_sel = 1'b1; c.wb_sel = WB_MEM;
        c.load_store_mode = inst[14:12];
      end
      OP_STORE: begin
        c.mem_rw = 1'b1; c.alu_src_2_sel = 1'b1; c.imm_sel = IMM_S;
        c.load_store_mode = inst[14:12];
      end
      OP_IMM: begin
        c.reg_wr_en = 1'b1; c.alu_src_2_sel = 1'b1;
        c.alu_sel = alu_op(inst[14:12], inst[30], 1'b0);
      end
      OP_REG: begin
        c.reg_wr_en = 1'b1;
        c.alu_sel = alu_op(inst[14:12], inst[30], 1'b1);
      end
      default: c.illegal = 1'b1;
    endcase
    bad_idx = (uses_rs1(inst) && idx_oob(inst[19:15], num_regs)) ||
              (uses_rs2(inst) && idx_oob(inst[24:20], num_regs)) ||
              (uses_rd(inst)  && idx_oob(inst[11:7],  num_regs));
    if (bad_idx) c.illegal = 1'b1;
    if (c.illegal) begin
      c.reg_wr_en = 1'b0;
      c.mem_rw    = 1'b0;
      c.pc_sel    = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/decode_pipe_regfile_bypass.sv
// Architectural register file: two combinational read ports, one write port, optional write bypass.
module regfile_bypass #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned BYPASS_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [4:0]      rs1_idx,
  input  logic [4:0]      rs2_idx,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  localparam int unsigned RA_W = $clog2(NUM_REGS);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic            wr_ok;

  function automatic logic in_range(input logic [4:0] idx);
    return {1'b0, idx} < 6'(NUM_REGS);
  endfunction

  // x0 and unimplemented indices read zero; bypass only applies to writes that would land.
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] idx);
    logic [XLEN-1:0] v;
    v = '0;
    if ((idx != 5'd0) && in_range(idx)) begin
      if ((BYPASS_EN != 0) && wb_en && (idx == wb_rd)) v = wb_data;
      else                                             v = regs[idx[RA_W-1:0]];
    end
    return v;
  endfunction

  assign wr_ok = wb_en && (wb_rd != 5'd0) && in_range(wb_rd);

  // Register storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wb_rd[RA_W-1:0]] <= wb_data;
    end
  end

  // Combinational read ports.
  always_comb begin
    rs1_data = read_port(rs1_idx);
    rs2_data = read_port(rs2_idx);
  end

endmodule

// File: rtl/decode_pipe.sv
// RV32I/RV32E decode stage with handshakes, load-use bubble, stall refresh and flush.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned BYPASS_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_inc,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_writeback,
  input  logic            i_flush,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [31:0]     o_decode_inst,
  output logic [XLEN-1:0] o_decode_pc,
  output logic [XLEN-1:0] o_decode_pc_inc,
  output logic [4:0]      o_decode_rs1,
  output logic [4:0]      o_decode_rs2,
  output logic [4:0]      o_decode_rd,
  output logic [XLEN-1:0] o_decode_data_1,
  output logic [XLEN-1:0] o_decode_data_2,
  output logic [XLEN-1:0] o_decode_immediate,
  output logic [2:0]      o_decode_load_store_mode,
  output logic            o_decode_reg_wr_en,
  output logic            o_decode_alu_src_1_sel,
  output logic            o_decode_alu_src_2_sel,
  output logic            o_decode_br_u,
  output logic            o_decode_mem_rw,
  output logic            o_decode_pc_sel,
  output logic [2:0]      o_decode_imm_sel,
  output logic [3:0]      o_decode_alu_sel,
  output logic [1:0]      o_decode_wb_sel,
  output logic            o_decode_illegal
);

  typedef struct packed {
    logic            valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_inc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] data_1;
    logic [XLEN-1:0] data_2;
    logic [XLEN-1:0] imm;
    ctrl_t           ctrl;
  } stage_t;

  stage_t          stage_q, stage_d;
  ctrl_t           dec_ctrl;
  logic [XLEN-1:0] rdata_1, rdata_2;
  logic            held_load, hazard, accept, take, refresh_1, refresh_2;

  regfile_bypass #(
    .XLEN      (XLEN),
    .NUM_REGS  (NUM_REGS),
    .BYPASS_EN (BYPASS_EN)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .wb_en    (i_wb_en),
    .wb_rd    (i_wb_rd),
    .wb_data  (i_writeback),
    .rs1_idx  (i_inst[19:15]),
    .rs2_idx  (i_inst[24:20]),
    .rs1_data (rdata_1),
    .rs2_data (rdata_2)
  );

  // Handshake and load-use hazard against the held instruction.
  always_comb begin
    dec_ctrl  = decode_ctrl(i_inst, NUM_REGS);
    held_load = stage_q.valid && (stage_q.inst[6:0] == OP_LOAD) && (stage_q.rd != 5'd0);
    hazard    = held_load &&
                ((uses_rs1(i_inst) && (i_inst[19:15] == stage_q.rd)) ||
                 (uses_rs2(i_inst) && (i_inst[24:20] == stage_q.rd)));
    o_ready   = i_flush || ((!stage_q.valid || i_ready) && !hazard);
    accept    = i_valid && o_ready;
    take      = stage_q.valid && i_ready;
    refresh_1 = i_wb_en && (i_wb_rd != 5'd0) && (i_wb_rd == stage_q.rs1);
    refresh_2 = i_wb_en && (i_wb_rd != 5'd0) && (i_wb_rd == stage_q.rs2);
  end

  // Next value of the output register: flush, accept, drain/bubble, or hold with refresh.
  always_comb begin
    stage_d = stage_q;
    if (i_flush) begin
      stage_d.valid = 1'b0;
    end else if (accept) begin
      stage_d.valid  = 1'b1;
      stage_d.inst   = i_inst;
      stage_d.pc     = i_pc;
      stage_d.pc_inc = i_pc_inc;
      stage_d.rs1    = i_inst[19:15];
      stage_d.rs2    = i_inst[24:20];
      stage_d.rd     = i_inst[11:7];
      stage_d.data_1 = rdata_1;
      stage_d.data_2 = rdata_2;
      stage_d.imm    = XLEN'($signed(gen_imm(i_inst, dec_ctrl.imm_sel)));
      stage_d.ctrl   = dec_ctrl;
    end else if (take) begin
      stage_d.valid = 1'b0;
    end else if (stage_q.valid) begin
      if (refresh_1) stage_d.data_1 = i_writeback;
      if (refresh_2) stage_d.data_2 = i_writeback;
    end
  end

  // Output pipeline register.
  always_ff @(posedge clk) begin
    if (!reset) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign o_valid                  = stage_q.valid;
  assign o_decode_inst            = stage_q.inst;
  assign o_decode_pc              = stage_q.pc;
  assign o_decode_pc_inc          = stage_q.pc_inc;
  assign o_decode_rs1             = stage_q.rs1;
  assign o_decode_rs2             = stage_q.rs2;
  assign o_decode_rd              = stage_q.rd;
  assign o_decode_data_1          = stage_q.data_1;
  assign o_decode_data_2          = stage_q.data_2;
  assign o_decode_immediate       = stage_q.imm;
  assign o_decode_load_store_mode = stage_q.ctrl.load_store_mode;
  assign o_decode_reg_wr_en       = stage_q.ctrl.reg_wr_en;
  assign o_decode_alu_src_1_sel   = stage_q.ctrl.alu_src_1_sel;
  assign o_decode_alu_src_2_sel   = stage_q.ctrl.alu_src_2_sel;
  assign o_decode_br_u            = stage_q.ctrl.br_u;
  assign o_decode_mem_rw          = stage_q.ctrl.mem_rw;
  assign o_decode_pc_sel          = stage_q.ctrl.pc_sel;
  assign o_decode_imm_sel         = stage_q.ctrl.imm_sel;
  assign o_decode_alu_sel         = stage_q.ctrl.alu_sel;
  assign o_decode_wb_sel          = stage_q.ctrl.wb_sel;
  assign o_decode_illegal         = stage_q.ctrl.illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: RV32I instance plus an RV32E instance on shared inputs.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        reset, i_valid, i_wb_en, i_flush, i_ready;
  logic [31:0] i_inst, i_pc, i_pc_inc, i_writeback;
  logic [4:0]  i_wb_rd;

  logic        o_ready, o_valid, reg_wr_en, src1, src2, br_u, mem_rw, pc_sel, illegal;
  logic [31:0] d_inst, d_pc, d_pc_inc, data_1, data_2, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  ls_mode, imm_sel;
  logic [3:0]  alu_sel;
  logic [1:0]  wb_sel;

  logic        e_ready, e_valid, e_reg_wr_en, e_src1, e_src2, e_br_u, e_mem_rw, e_pc_sel, e_illegal;
  logic [31:0] e_inst, e_pc, e_pc_inc, e_data_1, e_data_2, e_imm;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [2:0]  e_ls_mode, e_imm_sel;
  logic [3:0]  e_alu_sel;
  logic [1:0]  e_wb_sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_pipe #(.XLEN(32), .NUM_REGS(32), .BYPASS_EN(1)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready), .i_inst(i_inst),
    .i_pc(i_pc), .i_pc_inc(i_pc_inc), .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd),
    .i_writeback(i_writeback), .i_flush(i_flush), .i_ready(i_ready), .o_valid(o_valid),
    .o_decode_inst(d_inst), .o_decode_pc(d_pc), .o_decode_pc_inc(d_pc_inc),
    .o_decode_rs1(rs1), .o_decode_rs2(rs2), .o_decode_rd(rd),
    .o_decode_data_1(data_1), .o_decode_data_2(data_2), .o_decode_immediate(imm),
    .o_decode_load_store_mode(ls_mode), .o_decode_reg_wr_en(reg_wr_en),
    .o_decode_alu_src_1_sel(src1), .o_decode_alu_src_2_sel(src2), .o_decode_br_u(br_u),
    .o_decode_mem_rw(mem_rw), .o_decode_pc_sel(pc_sel), .o_decode_imm_sel(imm_sel),
    .o_decode_alu_sel(alu_sel), .o_decode_wb_sel(wb_sel), .o_decode_illegal(illegal)
  );

  decode_pipe #(.XLEN(32), .NUM_REGS(16), .BYPASS_EN(1)) dut_e (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(e_ready), .i_inst(i_inst),
    .i_pc(i_pc), .i_pc_inc(i_pc_inc), .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd),
    .i_writeback(i_writeback), .i_flush(i_flush), .i_ready(i_ready), .o_valid(e_valid),
    .o_decode_inst(e_inst), .o_decode_pc(e_pc), .o_decode_pc_inc(e_pc_inc),
    .o_decode_rs1(e_rs1), .o_decode_rs2(e_rs2), .o_decode_rd(e_rd),
    .o_decode_data_1(e_data_1), .o_decode_data_2(e_data_2), .o_decode_immediate(e_imm),
    .o_decode_load_store_mode(e_ls_mode), .o_decode_reg_wr_en(e_reg_wr_en),
    .o_decode_alu_src_1_sel(e_src1), .o_decode_alu_src_2_sel(e_src2), .o_decode_br_u(e_br_u),
    .o_decode_mem_rw(e_mem_rw), .o_decode_pc_sel(e_pc_sel), .o_decode_imm_sel(e_imm_sel),
    .o_decode_alu_sel(e_alu_sel), .o_decode_wb_sel(e_wb_sel), .o_decode_illegal(e_illegal)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] ri;
    reset = 1'b0; i_valid = 1'b1; i_inst = 32'h00400793; i_ready = 1'b1;
    step; step;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %h want 0", o_valid); end
    checks++;
    if ({d_inst, d_pc, d_pc_inc, rs1, rs2, rd, data_1, data_2, imm} !== '0) begin
      errors++; $display("FAIL reset_data_outputs: got inst=%h rd=%h imm=%h want all 0", d_inst, rd, imm);
    end
    checks++;
    if ({ls_mode, reg_wr_en, src1, src2, br_u, mem_rw, pc_sel, imm_sel, alu_sel, wb_sel, illegal} !== '0) begin
      errors++; $display("FAIL reset_ctrl_outputs: got alu=%h wb=%h wr=%b want all 0", alu_sel, wb_sel, reg_wr_en);
    end
    reset = 1'b1;
    // Back-to-back reads of x1..x31 through add x0,xi,xi.
    for (int i = 1; i < 32; i++) begin
      ri = {7'd0, 5'(i), 5'(i), 3'd0, 5'd0, 7'h33};
      i_inst = ri;
      step;
      checks++;
      if ({o_valid, data_1, data_2} !== {1'b1, 64'd0}) begin
        errors++; $display("FAIL reset_regfile_x%0d: got v=%b %h %h want 1 0 0", i, o_valid, data_1, data_2);
      end
    end
  endtask

  task automatic test_bypass;
    i_valid = 1'b1; i_ready = 1'b1; i_inst = 32'h00400793;
    step;
    checks++; if (imm !== 32'd4) begin errors++; $display("FAIL addi_imm: got %h want 4", imm); end
    checks++; if (src2 !== 1'b1) begin errors++; $display("FAIL addi_src2: got %b want 1", src2); end
    checks++; if (rd !== 5'd15) begin errors++; $display("FAIL addi_rd: got %0d want 15", rd); end
    checks++; if ({reg_wr_en, alu_sel, wb_sel} !== {1'b1, 4'd0, 2'd0}) begin
      errors++; $display("FAIL addi_ctrl: got wr=%b alu=%h wb=%h want 1 0 0", reg_wr_en, alu_sel, wb_sel); end
    i_inst = 32'h40F50533; i_wb_en = 1'b1; i_wb_rd = 5'd15; i_writeback = 32'd4;
    step;
    i_wb_en = 1'b0;
    checks++; if (data_2 !== 32'd4) begin errors++; $display("FAIL sub_bypass_data2: got %h want 4", data_2); end
    checks++; if (alu_sel !== 4'd1) begin errors++; $display("FAIL sub_alu_sel: got %h want 1", alu_sel); end
    checks++; if ({rs1, rs2, rd, data_1} !== {5'd10, 5'd15, 5'd10, 32'd0}) begin
      errors++; $display("FAIL sub_fields: got rs1=%0d rs2=%0d rd=%0d d1=%h want 10 15 10 0", rs1, rs2, rd, data_1); end
  endtask

  task automatic test_load_use;
    i_valid = 1'b1; i_ready = 1'b1; i_inst = 32'h0000A283;
    step;
    checks++; if ({o_valid, wb_sel, ls_mode, rd} !== {1'b1, 2'd1, 3'd2, 5'd5}) begin
      errors++; $display("FAIL lw_ctrl: got v=%b wb=%h ls=%h rd=%0d want 1 1 2 5", o_valid, wb_sel, ls_mode, rd); end
    i_inst = 32'h00508393;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL no_hazard_on_imm_field: got %b want 1", o_ready); end
    i_inst = 32'h00528333;
    #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL load_use_ready: got %b want 0", o_ready); end
    step;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL load_use_bubble: got %b want 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL after_bubble_ready: got %b want 1", o_ready); end
    step;
    checks++; if ({o_valid, d_inst, rd, data_1} !== {1'b1, 32'h00528333, 5'd6, 32'd0}) begin
      errors++; $display("FAIL load_use_issue: got v=%b inst=%h rd=%0d want 1 00528333 6", o_valid, d_inst, rd); end
  endtask

  task automatic test_stall_refresh;
    i_ready = 1'b0; i_valid = 1'b0;
    i_wb_en = 1'b1; i_wb_rd = 5'd5; i_writeback = 32'hDEADBEEF;
    #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", o_ready); end
    step;
    i_wb_en = 1'b0;
    checks++; if ({data_1, data_2} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      errors++; $display("FAIL stall_refresh: got %h %h want deadbeef deadbeef", data_1, data_2); end
    checks++; if ({o_valid, d_inst, rd, alu_sel, reg_wr_en} !== {1'b1, 32'h00528333, 5'd6, 4'd0, 1'b1}) begin
      errors++; $display("FAIL stall_hold: got v=%b inst=%h rd=%0d alu=%h", o_valid, d_inst, rd, alu_sel); end
    step;
    checks++; if ({o_valid, data_1} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL stall_hold_2: got v=%b d1=%h want 1 deadbeef", o_valid, data_1); end
  endtask

  task automatic test_flush;
    i_valid = 1'b1; i_inst = 32'h00700493; i_flush = 1'b1;
    i_wb_en = 1'b1; i_wb_rd = 5'd20; i_writeback = 32'h12345678;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", o_ready); end
    step;
    i_flush = 1'b0; i_wb_en = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", o_valid); end
    step;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flushed_reappears: got %b want 0", o_valid); end
    i_valid = 1'b1; i_inst = {7'd0, 5'd5, 5'd20, 3'd0, 5'd0, 7'h33};
    step;
    checks++; if ({data_1, data_2} !== {32'h12345678, 32'hDEADBEEF}) begin
      errors++; $display("FAIL regfile_after_flush: got %h %h want 12345678 deadbeef", data_1, data_2); end
  endtask

  task automatic test_immediates;
    i_valid = 1'b1; i_ready = 1'b1; i_pc = 32'h80; i_pc_inc = 32'h84; i_inst = 32'h123450B7;
    step;
    checks++; if ({imm, alu_sel, src2, imm_sel} !== {32'h12345000, 4'd10, 1'b1, 3'd3}) begin
      errors++; $display("FAIL lui: got imm=%h alu=%h s2=%b isel=%h", imm, alu_sel, src2, imm_sel); end
    checks++; if ({d_pc, d_pc_inc} !== {32'h80, 32'h84}) begin
      errors++; $display("FAIL lui_pc: got %h %h want 80 84", d_pc, d_pc_inc); end
    i_inst = 32'hFFDFF0EF;
    step;
    checks++; if ({imm, wb_sel, src1, pc_sel, imm_sel} !== {32'hFFFFFFFC, 2'd2, 1'b1, 1'b1, 3'd4}) begin
      errors++; $display("FAIL jal: got imm=%h wb=%h s1=%b pcs=%b isel=%h", imm, wb_sel, src1, pc_sel, imm_sel); end
    i_inst = 32'h0020E463;
    step;
    checks++; if ({imm, br_u, pc_sel, reg_wr_en, imm_sel} !== {32'd8, 1'b1, 1'b1, 1'b0, 3'd2}) begin
      errors++; $display("FAIL bltu: got imm=%h bru=%b pcs=%b wr=%b isel=%h", imm, br_u, pc_sel, reg_wr_en, imm_sel); end
    i_inst = 32'hFE20AC23;
    step;
    checks++; if ({imm, mem_rw, reg_wr_en, ls_mode, imm_sel} !== {32'hFFFFFFF8, 1'b1, 1'b0, 3'd2, 3'd1}) begin
      errors++; $display("FAIL sw: got imm=%h rw=%b wr=%b ls=%h isel=%h", imm, mem_rw, reg_wr_en, ls_mode, imm_sel); end
    i_pc = 32'd0; i_pc_inc = 32'd0;
  endtask

  task automatic test_rv32e;
    i_valid = 1'b1; i_ready = 1'b1; i_inst = 32'h01F00013;
    step;
    checks++; if ({e_valid, e_illegal, e_imm} !== {1'b1, 1'b0, 32'd31}) begin
      errors++; $display("FAIL e_addi_x0: got v=%b ill=%b imm=%h want 1 0 1f", e_valid, e_illegal, e_imm); end
    i_inst = 32'h01F00F93;
    step;
    checks++; if ({e_valid, e_illegal, e_reg_wr_en} !== 3'b110) begin
      errors++; $display("FAIL e_rd31: got v=%b ill=%b wr=%b want 1 1 0", e_valid, e_illegal, e_reg_wr_en); end
    checks++; if ({illegal, reg_wr_en} !== 2'b01) begin
      errors++; $display("FAIL i_rd31: got ill=%b wr=%b want 0 1", illegal, reg_wr_en); end
    i_inst = 32'h01FF8063;
    step;
    checks++; if ({e_illegal, e_pc_sel, pc_sel, illegal} !== 4'b1010) begin
      errors++; $display("FAIL beq_x31: got e_ill=%b e_pcs=%b pcs=%b ill=%b want 1 0 1 0", e_illegal, e_pc_sel, pc_sel, illegal); end
    i_inst = 32'h0000007F;
    step;
    checks++; if ({o_valid, illegal, reg_wr_en, mem_rw, pc_sel} !== 5'b11000) begin
      errors++; $display("FAIL unknown_opcode: got v=%b ill=%b wr=%b rw=%b pcs=%b", o_valid, illegal, reg_wr_en, mem_rw, pc_sel); end
    i_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; i_valid = 1'b0; i_inst = '0; i_pc = '0; i_pc_inc = '0;
    i_wb_en = 1'b0; i_wb_rd = '0; i_writeback = '0; i_flush = 1'b0; i_ready = 1'b0;
    #2;
    test_reset;
    test_bypass;
    test_load_use;
    test_stall_refresh;
    test_flush;
    test_immediates;
    test_rv32e;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised successor to the single-issue decode stage of the KLP32 RISC-V pipeline. Sits between fetch and execute.
- Decodes RV32I/RV32E base instructions (R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC) into the existing control bundle.
- Owns the register file, generates a full-width immediate, and applies writeback bypass.
- Adds valid/ready handshakes, load-use bubble insertion, stall-time operand refresh and flush. Results are held in an output pipeline register.

Parameters:
- XLEN, 32, datapath and register width.
- NUM_REGS, 32, architectural registers; 32 (RV32I) or 16 (RV32E).
- BYPASS_EN, 1, when 1, same-cycle writeback is forwarded to operand reads.
- RA_W, $clog2(NUM_REGS), derived localparam giving the register index width.

Ports:
- clk  in  1  clock; rising edge.
- reset  in  1  synchronous, active-low reset.
- i_valid  in  1  fetch has an instruction.
- o_ready  out  1  decode accepts this cycle.
- i_inst  in  32  instruction word.
- i_pc  in  XLEN  instruction PC.
- i_pc_inc  in  XLEN  PC+4.
- i_wb_en  in  1  writeback write enable.
- i_wb_rd  in  5  writeback destination register.
- i_writeback  in  XLEN  writeback data.
- i_flush  in  1  kill the held instruction and any incoming one.
- i_ready  in  1  execute accepts the held instruction.
- o_valid  out  1  output register holds a live instruction.
- o_decode_inst  out  32  held instruction.
- o_decode_pc  out  XLEN  held PC.
- o_decode_pc_inc  out  XLEN  held PC+4.
- o_decode_rs1  out  5  held source register 1 index.
- o_decode_rs2  out  5  held source register 2 index.
- o_decode_rd  out  5  held destination register index.
- o_decode_data_1  out  XLEN  held rs1 operand.
- o_decode_data_2  out  XLEN  held rs2 operand.
- o_decode_immediate  out  XLEN  sign-extended immediate.
- o_decode_load_store_mode  out  3  funct3 for LOAD/STORE, else 0.
- o_decode_reg_wr_en  out  1  instruction writes rd.
- o_decode_alu_src_1_sel  out  1  0 = rs1, 1 = PC.
- o_decode_alu_src_2_sel  out  1  0 = rs2, 1 = immediate.
- o_decode_br_u  out  1  unsigned branch compare (BLTU/BGEU).
- o_decode_mem_rw  out  1  1 = store.
- o_decode_pc_sel  out  1  1 = branch/jump candidate.
- o_decode_imm_sel  out  3  immediate format.
- o_decode_alu_sel  out  4  ALU operation.
- o_decode_wb_sel  out  2  writeback source.
- o_decode_illegal  out  1  unsupported opcode or register index.

Behaviour:
- **Reset** (reset==0 at posedge): o_valid=0, every o_decode_* output = 0, all regfile entries = 0. Reset overrides flush, handshake and writeback in the same cycle.
- **Handshake:**
  - accept = i_valid && o_ready; take = o_valid && i_ready.
  - o_ready = i_flush || ((!o_valid || i_ready) && !hazard).
  - Accept latency is 1 cycle; the result is registered on the accepting posedge.
- **Hazard:** hazard=1 when the held instruction is a LOAD (o_valid=1, rd!=0) and rd equals an rs1/rs2 that the incoming i_inst actually uses. Format usage:
  - I-type, LOAD, JALR: rs1 only.
  - U-type, J-type: neither.
- **Load-use bubble:** if hazard and take, next cycle o_valid=0 (bubble) and the incoming instruction is not consumed; it is accepted on the following cycle.
- **Hold:** if o_valid && !i_ready and there is no flush, all outputs hold. One exception: if i_wb_en && i_wb_rd!=0 and i_wb_rd matches o_decode_rs1/rs2, the matching data output is updated to i_writeback (refresh).
- **Flush:** next cycle o_valid=0 and the incoming instruction is dropped. Regfile writes still occur.
- **Regfile:**
  - Written at posedge when i_wb_en && i_wb_rd!=0.
  - x0 always reads 0.
  - Reads are combinational. With BYPASS_EN=1, a read whose index matches i_wb_rd with i_wb_en=1 and index!=0 returns i_writeback.
- **Immediate:** I, S, B, U, J formats are fully assembled and sign-extended to XLEN. Bit 0 is 0 for B and J; U has its low 12 bits = 0.
- **Illegal instructions:** an unknown opcode, or (NUM_REGS=16) any used index ≥16, gives illegal=1. Illegal forces reg_wr_en=0, mem_rw=0 and pc_sel=0; the instruction still flows with o_valid=1.
- **Opcode-driven controls:**
  - LUI: alu_sel=PASS_B, src2=imm.
  - AUIPC and JAL: src1=PC.
  - JAL and JALR: wb_sel=PC_INC.
  - LOAD: wb_sel=MEM.
  - STORE: mem_rw=1, reg_wr_en=0.
  - BRANCH: reg_wr_en=0, pc_sel=1, and br_u=funct3[1].

Decomposition:
- Package decode_pkg holds:
  - Opcode constants.
  - alu_sel enum: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 10.
  - imm_sel enum: I 0, S 1, B 2, U 3, J 4.
  - wb_sel enum: ALU 0, MEM 1, PC_INC 2.
  - A packed ctrl_t struct for the control bundle.
- One sub-module, regfile_bypass (parametrised XLEN/NUM_REGS/BYPASS_EN, two read ports, one write port). Control decode is a function in decode_pkg.

Test Plan:
- **Reset:** hold reset=0 for 2 cycles with i_valid=1 -> o_valid=0, every output 0; then reads of x1..x31 return 0.
- **Bypass:** accept 0x00400793 (addi x15,x0,4) -> o_decode_immediate=4, alu_src_2_sel=1, rd=15. Then accept 0x40F50533 (sub x10,x10,x15) in the same cycle as i_wb_en=1, i_wb_rd=15, i_writeback=4 -> o_decode_data_2=4, alu_sel=SUB.
- **Load-use:** accept 0x0000A283 (lw x5,0(x1)), then present 0x00528333 (add x6,x5,x5) with i_ready=1 -> o_ready=0 for one cycle, one bubble (o_valid=0), then add issued.
- **Stall refresh:** hold add x6,x5,x5 with i_ready=0 and write x5=0xDEADBEEF via writeback -> o_decode_data_1 = o_decode_data_2 = 0xDEADBEEF; other outputs unchanged.
- **Flush:** i_flush=1 with i_valid=1 and o_valid=1 -> next cycle o_valid=0, and the flushed instruction never appears.
- **RV32E:** with NUM_REGS=16, 0x01F00013 (addi x0,x0,31) -> legal. 0x01F00F93 (rd=31) -> o_decode_illegal=1, reg_wr_en=0.
